// File: rtl/noise_sched_pkg.sv
// Shared types, default widths and saturating add for the noise sweep scheduler.
// Optional NOISE_SCHED_STATS_EN adds per-epoch saturation/noisy counters.
package noise_sched_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int SCALE_W_DEF = 8;
    localparam int SYM_MAX     = 2 ** (DATA_W_DEF - 1) - 1;
    localparam int SYM_MIN     = -(2 ** (DATA_W_DEF - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN,
        S_GAP,
        S_DONE
    } state_e;

    // Saturates a + b to the signed range of a w-bit word.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/noise_sched_mixer.sv
// Registered scale-multiply, add and saturate datapath for the noise path.
// With NOISE_SCHED_STATS_EN it also keeps per-epoch sat/noisy counters.
module noise_sched_mixer
    import noise_sched_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SCALE_W = SCALE_W_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic                     mix_en,
    input  logic signed [DATA_W-1:0] sym_in,
    input  logic signed [DATA_W-1:0] noise_in,
    input  logic [SCALE_W-1:0]       scale,
`ifdef NOISE_SCHED_STATS_EN
    input  logic                     clr,
    output logic [15:0]              sat_cnt,
    output logic [15:0]              noisy_cnt,
`endif
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] sym_out
);

    localparam int PW = DATA_W + SCALE_W + 1;

    logic signed [PW-1:0]     prod;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] sym_d, sym_q;
    logic                     vld_d, vld_q;

    always_comb begin
        prod  = PW'(noise_in) * PW'(signed'({1'b0, scale}));
        y     = mix_en ? DATA_W'(sat_add(32'(sym_in), 32'(prod), DATA_W))
                       : sym_in;
        sym_d = in_valid ? y : sym_q;
        vld_d = in_valid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sym_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sym_q <= sym_d;
            vld_q <= vld_d;
        end
    end

    assign sym_out   = sym_q;
    assign out_valid = vld_q;

`ifdef NOISE_SCHED_STATS_EN
    logic signed [31:0] full;
    logic               noisy, clipped;
    logic [15:0]        sat_d, sat_q, noisy_d, noisy_q;

    always_comb begin
        full    = 32'(sym_in) + 32'(prod);
        noisy   = in_valid && mix_en;
        clipped = noisy && (sat_add(32'(sym_in), 32'(prod), DATA_W) != full);
        sat_d   = sat_q;
        noisy_d = noisy_q;
        if (clr) begin
            sat_d   = '0;
            noisy_d = '0;
        end else begin
            if (clipped && sat_q != 16'hFFFF) sat_d = sat_q + 16'd1;
            if (noisy && noisy_q != 16'hFFFF) noisy_d = noisy_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_q   <= '0;
            noisy_q <= '0;
        end else begin
            sat_q   <= sat_d;
            noisy_q <= noisy_d;
        end
    end

    assign sat_cnt   = sat_q;
    assign noisy_cnt = noisy_q;
`endif

endmodule

// File: rtl/noise_sched_ctrl.sv
// Noise sweep scheduler: warmup, noisy epochs with stepped amplitude, clean gaps.
// Define NOISE_SCHED_STATS_EN to expose sat_cnt/noisy_cnt per epoch.
module noise_sched_ctrl
    import noise_sched_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SCALE_W    = SCALE_W_DEF,
    parameter int CNT_W      = 16,
    parameter int WARMUP_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     abort,
    input  logic [SCALE_W-1:0]       cfg_scale_start,
    input  logic [SCALE_W-1:0]       cfg_scale_step,
    input  logic [SCALE_W-1:0]       cfg_scale_max,
    input  logic [CNT_W-1:0]         cfg_epoch_len,
    input  logic [CNT_W-1:0]         cfg_gap_len,
    output logic                     noise_en,
    input  logic signed [DATA_W-1:0] noise_in,
    input  logic                     noise_in_valid,
    input  logic signed [DATA_W-1:0] sym_in,
    input  logic                     sym_in_valid,
    output logic signed [DATA_W-1:0] sym_out,
    output logic                     sym_out_valid,
    output logic [SCALE_W-1:0]       cur_scale,
    output logic [7:0]               epoch_idx,
`ifdef NOISE_SCHED_STATS_EN
    output logic [15:0]              sat_cnt,
    output logic [15:0]              noisy_cnt,
`endif
    output logic                     busy,
    output logic                     done
);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYC - 1);

    state_e             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q, cnt_inc;
    logic [CNT_W-1:0]   elen_d, elen_q, glen_d, glen_q;
    logic [SCALE_W-1:0] scale_d, scale_q, step_d, step_q, max_d, max_q;
    logic [SCALE_W:0]   nxt;
    logic [7:0]         epoch_d, epoch_q;
    logic               noise_en_d, noise_en_q;
    logic               busy_d, busy_q, done_d, done_q;
    logic               do_adv, in_sweep;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign nxt      = {1'b0, scale_q} + {1'b0, step_q};
    assign in_sweep = (state_q == S_WARMUP) || (state_q == S_RUN)
                   || (state_q == S_GAP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        elen_d  = elen_q;
        glen_d  = glen_q;
        scale_d = scale_q;
        step_d  = step_q;
        max_d   = max_q;
        epoch_d = epoch_q;
        do_adv  = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                step_d  = cfg_scale_step;
                max_d   = cfg_scale_max;
                elen_d  = (cfg_epoch_len == '0) ? CNT_W'(1) : cfg_epoch_len;
                glen_d  = cfg_gap_len;
                scale_d = cfg_scale_start;
                epoch_d = '0;
                cnt_d   = '0;
                state_d = S_WARMUP;
            end
            S_WARMUP: begin
                cnt_d = cnt_inc;
                if (cnt_q == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: if (sym_in_valid) begin
                cnt_d = cnt_inc;
                if (cnt_inc >= elen_q) begin
                    cnt_d = '0;
                    if (glen_q == '0) do_adv = 1'b1;
                    else state_d = S_GAP;
                end
            end
            S_GAP: if (sym_in_valid) begin
                cnt_d = cnt_inc;
                if (cnt_inc >= glen_q) begin
                    cnt_d  = '0;
                    do_adv = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // The 9-bit sum catches wrap past 255 as "beyond max".
        if (do_adv) begin
            if (step_q == '0 || nxt > {1'b0, max_q}) begin
                state_d = S_DONE;
            end else begin
                scale_d = nxt[SCALE_W-1:0];
                epoch_d = epoch_q + 8'd1;
                state_d = S_RUN;
            end
        end
        if (abort && in_sweep) begin
            state_d = S_DONE;
            cnt_d   = '0;
            scale_d = scale_q;
            epoch_d = epoch_q;
        end
        noise_en_d = (state_d == S_WARMUP) || (state_d == S_RUN);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            elen_q     <= '0;
            glen_q     <= '0;
            scale_q    <= '0;
            step_q     <= '0;
            max_q      <= '0;
            epoch_q    <= '0;
            noise_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            elen_q     <= elen_d;
            glen_q     <= glen_d;
            scale_q    <= scale_d;
            step_q     <= step_d;
            max_q      <= max_d;
            epoch_q    <= epoch_d;
            noise_en_q <= noise_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign noise_en  = noise_en_q;
    assign cur_scale = scale_q;
    assign epoch_idx = epoch_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef NOISE_SCHED_STATS_EN
    logic epoch_start;
    assign epoch_start = (state_d == S_RUN) && (state_q != S_RUN || do_adv);
`endif

    noise_sched_mixer #(
        .DATA_W  (DATA_W),
        .SCALE_W (SCALE_W)
    ) u_mixer (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (sym_in_valid),
        .mix_en    ((state_q == S_RUN) && noise_in_valid),
        .sym_in    (sym_in),
        .noise_in  (noise_in),
        .scale     (scale_q),
`ifdef NOISE_SCHED_STATS_EN
        .clr       (epoch_start),
        .sat_cnt   (sat_cnt),
        .noisy_cnt (noisy_cnt),
`endif
        .out_valid (sym_out_valid),
        .sym_out   (sym_out)
    );

endmodule

// File: tb/tb_noise_sched_ctrl.sv
// Directed bench for noise_sched_ctrl with an output scoreboard queue.
// Stats ports are connected only when NOISE_SCHED_STATS_EN is defined.
module tb_noise_sched_ctrl;
    import noise_sched_pkg::*;

    localparam int DW   = 8;
    localparam int SW   = 8;
    localparam int CW   = 16;
    localparam int WARM = 16;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [SW-1:0] cfg_scale_start = '0;
    logic [SW-1:0] cfg_scale_step = '0;
    logic [SW-1:0] cfg_scale_max = '0;
    logic [CW-1:0] cfg_epoch_len = '0;
    logic [CW-1:0] cfg_gap_len = '0;
    logic signed [DW-1:0] noise_in = '0;
    logic noise_in_valid = 1'b0;
    logic signed [DW-1:0] sym_in = '0;
    logic sym_in_valid = 1'b0;
    logic noise_en;
    logic signed [DW-1:0] sym_out;
    logic sym_out_valid;
    logic [SW-1:0] cur_scale;
    logic [7:0] epoch_idx;
    logic busy;
    logic done;
`ifdef NOISE_SCHED_STATS_EN
    logic [15:0] sat_cnt;
    logic [15:0] noisy_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int expq[$];

    noise_sched_ctrl #(
        .DATA_W(DW), .SCALE_W(SW), .CNT_W(CW), .WARMUP_CYC(WARM)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_scale_start(cfg_scale_start), .cfg_scale_step(cfg_scale_step),
        .cfg_scale_max(cfg_scale_max), .cfg_epoch_len(cfg_epoch_len),
        .cfg_gap_len(cfg_gap_len), .noise_en(noise_en),
        .noise_in(noise_in), .noise_in_valid(noise_in_valid),
        .sym_in(sym_in), .sym_in_valid(sym_in_valid),
        .sym_out(sym_out), .sym_out_valid(sym_out_valid),
        .cur_scale(cur_scale), .epoch_idx(epoch_idx),
`ifdef NOISE_SCHED_STATS_EN
        .sat_cnt(sat_cnt), .noisy_cnt(noisy_cnt),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > SYM_MAX) return SYM_MAX;
        if (v < SYM_MIN) return SYM_MIN;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rstn && sym_out_valid) begin
            if (expq.size() == 0) chk("sb_underflow", expq.size(), 1);
            else chk("sym_out", sym_out, expq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input int n, input bit nv, input int e);
        sym_in = DW'(s);
        noise_in = DW'(n);
        sym_in_valid = 1'b1;
        noise_in_valid = nv;
        expq.push_back(e);
        tick();
        sym_in_valid = 1'b0;
        noise_in_valid = 1'b0;
    endtask

    task automatic launch(input int st, input int stp, input int mx,
                          input int el, input int gl);
        cfg_scale_start = SW'(st);
        cfg_scale_step = SW'(stp);
        cfg_scale_max = SW'(mx);
        cfg_epoch_len = CW'(el);
        cfg_gap_len = CW'(gl);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (WARM) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        #1;
        chk("rst_sym_out", sym_out, 0);
        chk("rst_valid", sym_out_valid, 0);
        chk("rst_noise_en", noise_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_scale", cur_scale, 0);
        chk("rst_epoch", epoch_idx, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // idle passthrough ignores noise
        send(5, 1, 1, 5);
        chk("idle_noise_en", noise_en, 0);
        chk("idle_busy", busy, 0);

        // three-epoch sweep; a second start mid-warmup must be ignored
        cfg_scale_start = 8'd2;
        cfg_scale_step = 8'd2;
        cfg_scale_max = 8'd6;
        cfg_epoch_len = 16'd4;
        cfg_gap_len = 16'd2;
        start = 1'b1;
        tick();
        chk("warm_noise_en", noise_en, 1);
        chk("warm_busy", busy, 1);
        cfg_scale_start = 8'd50;
        cfg_epoch_len = 16'd9;
        tick();
        start = 1'b0;
        chk("start_busy_ignored", cur_scale, 2);
        repeat (WARM - 1) tick();
        for (int e = 0; e < 3; e++) begin
            for (int k = 0; k < 4; k++) begin
                send(10 + k, 1, 1, sat8(10 + k + 2 * (e + 1)));
                if (k == 0) begin
                    chk("sweep_epoch_idx", epoch_idx, e);
                    chk("sweep_scale", cur_scale, 2 * (e + 1));
                    chk("run_noise_en", noise_en, 1);
                end
            end
            for (int k = 0; k < 2; k++) begin
                send(20 + k, 1, 1, 20 + k);
                if (k == 0) chk("gap_noise_en", noise_en, 0);
            end
        end
        chk("sweep_done", done, 1);
        tick();
        chk("sweep_done_clr", done, 0);
        chk("sweep_idle", busy, 0);
        chk("sweep_last_epoch", epoch_idx, 2);

        // saturation both ways plus an in-range value, step=0 -> one epoch
        launch(100, 0, 100, 3, 0);
        send(100, 1, 1, sat8(100 + 100));
        send(-100, -1, 1, sat8(-100 - 100));
        send(20, -1, 1, sat8(20 - 100));
        chk("sat_done", done, 1);
        tick();

        // sparse valid: RUN lasts exactly 4 valid symbols
        launch(3, 0, 3, 4, 0);
        send(1, 1, 1, 4);
        tick();
        send(2, 1, 0, 2);
        tick();
        send(3, -1, 1, 0);
        tick();
        chk("sparse_still_run", noise_en, 1);
        send(4, 1, 1, 7);
        chk("sparse_done", done, 1);
        tick();

        // abort during epoch 1
        launch(1, 1, 10, 2, 0);
        send(0, 1, 1, 1);
        send(0, 1, 1, 1);
        send(5, 1, 1, 7);
        chk("abort_epoch", epoch_idx, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_noise_en", noise_en, 0);
        tick();
        chk("abort_idle", busy, 0);
        chk("abort_done_clr", done, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_done", done, 0);

        // async reset mid-gap
        launch(1, 1, 10, 1, 3);
        send(7, 1, 1, 8);
        send(7, 1, 1, 7);
        tick();
        chk("gap_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_sym_out", sym_out, 0);
        chk("mid_rst_noise_en", noise_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_scale", cur_scale, 0);
        chk("mid_rst_epoch", epoch_idx, 0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_done_after_rst", done, 0);
        end

        // start above max still runs one epoch
        launch(10, 1, 5, 2, 0);
        send(3, 1, 1, 13);
        send(3, -1, 1, -7);
        chk("over_max_done", done, 1);
        chk("over_max_scale", cur_scale, 10);
        chk("over_max_epoch", epoch_idx, 0);
        tick();

        // epoch_len=0 behaves as one symbol
        launch(7, 0, 7, 0, 0);
        send(2, 1, 1, 9);
        chk("elen0_done", done, 1);
        send(2, 1, 1, 2);
        chk("elen0_idle", busy, 0);

        tick();
        tick();
        chk("sb_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
